// File: rtl/pad_io_ctrl_if.sv
// Pad controller bus: core-side controls, padring connections and interrupt status.
// The slave modport is the controller; the master modport is whoever drives it.
interface pad_io_ctrl_if #(
   parameter int NPads = 64
) ();
   logic [NPads-1:0] out_i;
   logic [NPads-1:0] oe_i;
   logic [NPads-1:0] filter_en_i;
   logic [NPads-1:0] intr_rise_en_i;
   logic [NPads-1:0] intr_fall_en_i;
   logic [NPads-1:0] intr_clear_i;
   logic [NPads-1:0] pad_in_i;
   logic [NPads-1:0] pad_out_o;
   logic [NPads-1:0] pad_oe_o;
   logic [NPads-1:0] in_o;
   logic [NPads-1:0] intr_state_o;
   logic             intr_o;

   modport master (
      output out_i, oe_i, filter_en_i, intr_rise_en_i, intr_fall_en_i, intr_clear_i, pad_in_i,
      input  pad_out_o, pad_oe_o, in_o, intr_state_o, intr_o
   );

   modport slave (
      input  out_i, oe_i, filter_en_i, intr_rise_en_i, intr_fall_en_i, intr_clear_i, pad_in_i,
      output pad_out_o, pad_oe_o, in_o, intr_state_o, intr_o
   );
endinterface

// File: rtl/pad_io_ctrl.sv
// Per-pad output registering, input synchronisation with an optional stability filter,
// and sticky edge interrupts. Every pad is an independent slice.
module pad_io_ctrl #(
   parameter int NPads        = 64,
   parameter int FilterCycles = 16
) (
   input logic            clk_i,
   input logic            rst_i,
   pad_io_ctrl_if.slave   bus
);
   localparam int              CntW   = $clog2(FilterCycles) + 1;
   localparam logic [CntW-1:0] CntMax = CntW'(FilterCycles - 1);

   logic [NPads-1:0] pad_out_q, pad_oe_q;
   logic [NPads-1:0] sync1_q, sync_q;
   logic [NPads-1:0] filt_q, filt_d;
   logic [NPads-1:0] prev_q;
   logic [NPads-1:0] intr_state_q, intr_state_d;
   logic [NPads-1:0] rise, fall, set_evt;
   logic [CntW-1:0]  cnt_q [NPads];
   logic [CntW-1:0]  cnt_d [NPads];

   // A mismatch must persist for FilterCycles consecutive samples; any match restarts the count.
   always_comb begin
      filt_d = filt_q;
      for (int i = 0; i < NPads; i++) begin
         cnt_d[i] = '0;
         if (!bus.filter_en_i[i]) begin
            filt_d[i] = sync_q[i];
         end else if (sync_q[i] != filt_q[i]) begin
            if (cnt_q[i] == CntMax) filt_d[i] = sync_q[i];
            else                    cnt_d[i] = cnt_q[i] + CntW'(1);
         end
      end
   end

   assign rise         = filt_q & ~prev_q;
   assign fall         = ~filt_q & prev_q;
   assign set_evt      = (rise & bus.intr_rise_en_i) | (fall & bus.intr_fall_en_i);
   // A new event takes priority over a coincident clear so it is never lost.
   assign intr_state_d = set_evt | (intr_state_q & ~bus.intr_clear_i);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pad_out_q    <= '0;
         pad_oe_q     <= '0;
         sync1_q      <= '0;
         sync_q       <= '0;
         filt_q       <= '0;
         prev_q       <= '0;
         intr_state_q <= '0;
         for (int i = 0; i < NPads; i++) cnt_q[i] <= '0;
      end else begin
         pad_out_q    <= bus.out_i;
         pad_oe_q     <= bus.oe_i;
         sync1_q      <= bus.pad_in_i;
         sync_q       <= sync1_q;
         filt_q       <= filt_d;
         prev_q       <= filt_q;
         intr_state_q <= intr_state_d;
         for (int i = 0; i < NPads; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign bus.pad_out_o    = pad_out_q;
   assign bus.pad_oe_o     = pad_oe_q;
   assign bus.in_o         = filt_q;
   assign bus.intr_state_o = intr_state_q;
   assign bus.intr_o       = |intr_state_q;
endmodule

// File: doc/pad_io_ctrl.md
PAD_IO_CTRL -- requirements
Module: pad_io_ctrl

Interface
REQ-001 Parameter NPads, default 64, number of pads driven and sampled; range 1..64.
REQ-002 Parameter FilterCycles, default 16, consecutive stable cycles a filtered input needs before it is accepted; range 2..255.
REQ-003 clk_i  input  1  single block clock.
REQ-004 rst_i  input  1  reset; asynchronous, active-high.
REQ-005 out_i  input  NPads  core output value per pad.
REQ-006 oe_i  input  NPads  core output enable per pad.
REQ-007 filter_en_i  input  NPads  per-pad input glitch-filter enable.
REQ-008 intr_rise_en_i  input  NPads  per-pad rising-edge interrupt enable.
REQ-009 intr_fall_en_i  input  NPads  per-pad falling-edge interrupt enable.
REQ-010 intr_clear_i  input  NPads  per-pad write-1-to-clear pulse for interrupt state.
REQ-011 pad_out_o  output  NPads  registered output value to the padring.
REQ-012 pad_oe_o  output  NPads  registered output enable to the padring.
REQ-013 pad_in_i  input  NPads  raw, asynchronous input value from the padring.
REQ-014 in_o  output  NPads  synchronised, optionally filtered input value.
REQ-015 intr_state_o  output  NPads  sticky per-pad interrupt status.
REQ-016 intr_o  output  1  OR-reduction of intr_state_o.

Function
REQ-017 pad_out_o and pad_oe_o SHALL equal out_i and oe_i delayed by exactly 1 clk_i cycle.
REQ-018 pad_in_i SHALL pass through a 2-flop synchroniser per pad (sync_q) before any other use.
REQ-019 Each pad SHALL hold a filtered-value register filt_q, driven onto in_o, and a counter cnt_q of width clog2(FilterCycles)+1.
REQ-020 filter_en_i=0: filt_q <= sync_q every cycle and cnt_q <= 0; in_o latency is 3 cycles from pad_in_i.
REQ-021 filter_en_i=1, sync_q == filt_q: cnt_q <= 0 and filt_q holds.
REQ-022 filter_en_i=1, sync_q != filt_q, cnt_q < FilterCycles-1: cnt_q <= cnt_q+1 and filt_q holds.
REQ-023 filter_en_i=1, sync_q != filt_q, cnt_q == FilterCycles-1: filt_q <= sync_q and cnt_q <= 0.
REQ-024 A pad level held stable for FilterCycles synchronised cycles SHALL therefore propagate to in_o with latency FilterCycles+2 cycles; any shorter pulse SHALL be fully suppressed.
REQ-025 A mismatch that ends before the threshold SHALL return cnt_q to 0; counts SHALL never accumulate across separate glitches.
REQ-026 Deasserting filter_en_i mid-count SHALL zero cnt_q and load sync_q on that same edge.
REQ-027 Edge detection SHALL use filt_q and its 1-cycle-delayed copy prev_q: rise = filt_q & ~prev_q; fall = ~filt_q & prev_q.
REQ-028 intr_state_o[i] SHALL set on the cycle after (rise[i] & intr_rise_en_i[i]) | (fall[i] & intr_fall_en_i[i]).
REQ-029 intr_state_o[i] SHALL clear on the cycle after intr_clear_i[i]=1 with no set event; set SHALL win when set and clear coincide.
REQ-030 Changing the interrupt enables SHALL NOT alter existing intr_state_o bits.
REQ-031 intr_o SHALL be combinational |intr_state_o, with no further delay.
REQ-032 Pads SHALL be fully independent; no event on one pad SHALL affect another.

Reset
REQ-033 While rst_i=1, and immediately on assertion, every flop SHALL be 0: pad_out_o, pad_oe_o, sync_q, filt_q, prev_q, cnt_q, intr_state_o; intr_o SHALL be 0.
REQ-034 Because prev_q and filt_q both reset to 0, a pad held high through reset SHALL produce exactly one rise event after reset release once its value reaches filt_q.
REQ-035 Reset asserted mid-filter SHALL discard the count; filtering SHALL restart from 0 after release.

Verification
REQ-036 out_i=0xA5, oe_i=0x0F, NPads=8: pad_out_o=0xA5 and pad_oe_o=0x0F exactly 1 cycle later.
REQ-037 FilterCycles=4, filter_en=1, pad0 high for 3 cycles then low: in_o[0] stays 0 and intr_state_o stays 0.
REQ-038 FilterCycles=4, filter_en=1, pad0 goes high and stays high, rise_en=1: in_o[0]=1 at cycle 6; intr_state_o[0]=1 and intr_o=1 at cycle 7.
REQ-039 intr_state_o[0]=1; intr_clear_i[0] pulsed on the same cycle as a new fall event with fall_en=1: intr_state_o[0] remains 1; a clear with no event then gives 0 next cycle.
REQ-040 filter_en=0, pad1 toggles every cycle, rise_en=fall_en=1: in_o[1] follows at 3-cycle latency; intr_state_o[1]=1 from cycle 4 onward.
REQ-041 rst_i asserted asynchronously mid-count with intr_state_o=0xFF: all outputs are 0 immediately; after release a pad held high yields one rise interrupt.
